// File: rtl/instr_pipe_regs_pkg.sv
// Shared RV32I definitions for the pipeline-register slice: opcodes, the bubble
// encoding and field extraction helpers.
package instr_pipe_regs_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // addi x0,x0,0: decodes as a harmless ALU op with no architectural effect
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  function automatic logic [6:0] get_opcode(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [4:0] get_rd(input logic [31:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [4:0] get_rs1(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] get_rs2(input logic [31:0] instr);
    return instr[24:20];
  endfunction

  // Only the U-type and JAL formats lack an rs1 field.
  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_OP || opcode == OP_STORE || opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/instr_pipe_regs_hazard_detect.sv
// Load-use hazard detector: flags a decode-stage instruction that reads the
// destination of a load currently in execute.
module hazard_detect
  import instr_pipe_regs_pkg::*;
(
  input  logic [31:0] instr_d,
  input  logic [31:0] instr_x,
  output logic        hazard
);

  logic [6:0] opcode_d;
  logic [6:0] opcode_x;
  logic [4:0] rd_x;
  logic       rs1_match;
  logic       rs2_match;

  always_comb begin
    opcode_d  = get_opcode(instr_d);
    opcode_x  = get_opcode(instr_x);
    rd_x      = get_rd(instr_x);
    rs1_match = (get_rs1(instr_d) == rd_x) && uses_rs1(opcode_d);
    rs2_match = (get_rs2(instr_d) == rd_x) && uses_rs2(opcode_d);
    // x0 is never really written, so a load to x0 cannot create a dependency
    hazard    = (opcode_x == OP_LOAD) && (rd_x != 5'd0) && (rs1_match || rs2_match);
  end

endmodule

// File: rtl/instr_pipe_regs.sv
// Instruction/PC pipeline registers IF/ID .. MEM/WB with load-use bubbling,
// branch flush, global hold and saturating stall/flush event counters.
module instr_pipe_regs
  import instr_pipe_regs_pkg::*;
#(
  parameter logic [31:0] NOP      = NOP_INSTR,
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic [31:0]      instr_f,
  input  logic [31:0]      pc_f,
  input  logic             pc_sel,
  output logic [31:0]      instr_d,
  output logic [31:0]      pc_d,
  output logic [31:0]      instr_x,
  output logic [31:0]      pc_x,
  output logic [31:0]      instr_m,
  output logic [31:0]      instr_w,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic hazard;

  hazard_detect u_hazard_detect (
    .instr_d (instr_d),
    .instr_x (instr_x),
    .hazard  (hazard)
  );

  // A taken branch makes the stalled instruction wrong-path, so flush wins.
  always_comb begin
    flush = pc_sel & ~hold;
    stall = hazard & ~pc_sel & ~hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_d   <= NOP;
      instr_x   <= NOP;
      instr_m   <= NOP;
      instr_w   <= NOP;
      pc_d      <= RESET_PC;
      pc_x      <= RESET_PC;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!hold) begin
      if (flush) begin
        // PCs of squashed slots are meaningless; leave them as they were
        instr_d <= NOP;
        instr_x <= NOP;
      end else if (stall) begin
        instr_x <= NOP;
      end else begin
        instr_d <= instr_f;
        pc_d    <= pc_f;
        instr_x <= instr_d;
        pc_x    <= pc_d;
      end
      instr_m <= instr_x;
      instr_w <= instr_m;

      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_pipe_regs.sv
// Bench for instr_pipe_regs: vector table, directed corner sequences and a
// randomized phase against a reference pipeline model.
module tb_instr_pipe_regs;

  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] I1    = 32'h00100093;
  localparam logic [31:0] I2    = 32'h00200113;
  localparam logic [31:0] I3    = 32'h00308193;
  localparam logic [31:0] I4    = 32'h00410213;
  localparam logic [31:0] LW5   = 32'h0000a283; // lw x5,0(x1)
  localparam logic [31:0] ADD5  = 32'h00228333; // add x6,x5,x2
  localparam logic [31:0] LW0   = 32'h0000a003; // lw x0,0(x1)
  localparam logic [31:0] ADD0  = 32'h00200333; // add x6,x0,x2
  localparam logic [31:0] LUI5  = 32'h000012b7; // lui x5,1
  localparam logic [31:0] BEQ   = 32'h00208063; // beq x1,x2,0
  localparam logic [31:0] FILL  = 32'h00700393; // addi x7,x0,7

  // clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hold, pc_sel;
  logic [31:0] instr_f, pc_f;
  logic [31:0] instr_d, pc_d, instr_x, pc_x, instr_m, instr_w;
  logic        stall, flush;
  logic [15:0] stall_cnt, flush_cnt;
  logic [31:0] s_instr_d, s_pc_d, s_instr_x, s_pc_x, s_instr_m, s_instr_w;
  logic        s_stall, s_flush;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  instr_pipe_regs dut (
    .clk(clk), .rst(rst), .hold(hold), .instr_f(instr_f), .pc_f(pc_f), .pc_sel(pc_sel),
    .instr_d(instr_d), .pc_d(pc_d), .instr_x(instr_x), .pc_x(pc_x),
    .instr_m(instr_m), .instr_w(instr_w), .stall(stall), .flush(flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  instr_pipe_regs #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .hold(hold), .instr_f(instr_f), .pc_f(pc_f), .pc_sel(pc_sel),
    .instr_d(s_instr_d), .pc_d(s_pc_d), .instr_x(s_instr_x), .pc_x(s_pc_x),
    .instr_m(s_instr_m), .instr_w(s_instr_w), .stall(s_stall), .flush(s_flush),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  int checks = 0;
  int errors = 0;

  // reference model: four in-flight slots D,X,M,W plus event totals
  logic [31:0] slot [4];
  logic [31:0] m_pcd, m_pcx;
  int          n_stall, n_flush;
  bit          m_valid = 0;

  function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
    logic [6:0] op;
    bit         has_rs1, has_rs2;
    op      = ins[6:0];
    has_rs1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    has_rs2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    return (has_rs1 && ins[19:15] == r) || (has_rs2 && ins[24:20] == r);
  endfunction

  function automatic bit model_hazard();
    logic [31:0] ld;
    ld = slot[1];
    return (ld[6:0] == 7'b0000011) && (ld[11:7] != 5'd0) && reads_reg(slot[0], ld[11:7]);
  endfunction

  function automatic logic [31:0] sat(input int n, input int max);
    return (n > max) ? max : n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit exp_stall;
    if (!m_valid) return;
    exp_stall = model_hazard() && !pc_sel && !hold;
    check("instr_d", instr_d, slot[0]);
    check("instr_x", instr_x, slot[1]);
    check("instr_m", instr_m, slot[2]);
    check("instr_w", instr_w, slot[3]);
    check("pc_d", pc_d, m_pcd);
    check("pc_x", pc_x, m_pcx);
    check("stall", 32'(stall), 32'(exp_stall));
    check("flush", 32'(flush), 32'(pc_sel && !hold));
    check("stall_cnt", 32'(stall_cnt), sat(n_stall, 65535));
    check("flush_cnt", 32'(flush_cnt), sat(n_flush, 65535));
    check("sat_stall_cnt", 32'(s_stall_cnt), sat(n_stall, 3));
    check("sat_flush_cnt", 32'(s_flush_cnt), sat(n_flush, 3));
  endtask

  task automatic model_edge();
    logic [31:0] older [2];
    if (rst) begin
      for (int i = 0; i < 4; i++) slot[i] = NOP;
      m_pcd = 32'h0; m_pcx = 32'h0;
      n_stall = 0; n_flush = 0;
      m_valid = 1;
    end else if (!hold && m_valid) begin
      older[0] = slot[1];
      older[1] = slot[2];
      if (pc_sel) begin
        slot[0] = NOP; slot[1] = NOP;
        n_flush++;
      end else if (model_hazard()) begin
        slot[1] = NOP;
        n_stall++;
      end else begin
        slot[1] = slot[0]; m_pcx = m_pcd;
        slot[0] = instr_f; m_pcd = pc_f;
      end
      slot[2] = older[0];
      slot[3] = older[1];
    end
  endtask

  // driver tasks: inputs change at the falling edge, outputs sampled 1 ns later
  task automatic apply(input logic r, input logic h, input logic ps, input logic [31:0] ins);
    rst = r; hold = h; pc_sel = ps; instr_f = ins; pc_f = $urandom;
    #1;
    check_model();
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic step(input logic r, input logic h, input logic ps, input logic [31:0] ins);
    apply(r, h, ps, ins);
    finish_cycle();
  endtask

  task automatic do_reset();
    step(1, 0, 0, $urandom);
    step(1, 0, 0, $urandom);
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        chk;
    logic [31:0] d, x, w;
    logic        stall;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b1, 32'hdeadbeef, 1'b0, NOP,  NOP,  NOP, 1'b0};
    tbl[1]  = '{1'b1, 32'h12345678, 1'b1, NOP,  NOP,  NOP, 1'b0};
    tbl[2]  = '{1'b0, I1,           1'b1, NOP,  NOP,  NOP, 1'b0};
    tbl[3]  = '{1'b0, I2,           1'b1, I1,   NOP,  NOP, 1'b0};
    tbl[4]  = '{1'b0, I3,           1'b1, I2,   I1,   NOP, 1'b0};
    tbl[5]  = '{1'b0, I4,           1'b1, I3,   I2,   NOP, 1'b0};
    tbl[6]  = '{1'b0, NOP,          1'b1, I4,   I3,   I1,  1'b0};
    tbl[7]  = '{1'b0, NOP,          1'b1, NOP,  I4,   I2,  1'b0};
    tbl[8]  = '{1'b0, LW5,          1'b1, NOP,  NOP,  I3,  1'b0};
    tbl[9]  = '{1'b0, ADD5,         1'b1, LW5,  NOP,  I4,  1'b0};
    tbl[10] = '{1'b0, FILL,         1'b1, ADD5, LW5,  NOP, 1'b1};
    tbl[11] = '{1'b0, FILL,         1'b1, ADD5, NOP,  NOP, 1'b0};
    tbl[12] = '{1'b0, NOP,          1'b1, FILL, ADD5, LW5, 1'b0};

    rst = 1; hold = 0; pc_sel = 0; instr_f = '0; pc_f = '0;
    @(negedge clk);
    #1;

    // reset, straight-line latency and one load-use bubble
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].rst, 1'b0, 1'b0, tbl[i].instr);
      if (tbl[i].chk) begin
        check($sformatf("tbl%0d_d", i), instr_d, tbl[i].d);
        check($sformatf("tbl%0d_x", i), instr_x, tbl[i].x);
        check($sformatf("tbl%0d_w", i), instr_w, tbl[i].w);
        check($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].stall));
        check($sformatf("tbl%0d_flush", i), 32'(flush), 32'h0);
      end
      if (i == 1) begin
        check("rst_pc_d", pc_d, 32'h0);
        check("rst_pc_x", pc_x, 32'h0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'h0);
        check("rst_instr_m", instr_m, NOP);
      end
      finish_cycle();
    end
    check("loaduse_stall_cnt", 32'(stall_cnt), 32'd1);

    // loads to x0 and a LUI consumer never stall
    do_reset();
    step(0, 0, 0, LW0);
    step(0, 0, 0, ADD0);
    apply(0, 0, 0, FILL);
    check("lw_x0_no_stall", 32'(stall), 32'h0);
    finish_cycle();
    step(0, 0, 0, LW5);
    step(0, 0, 0, LUI5);
    apply(0, 0, 0, FILL);
    check("lui_no_stall", 32'(stall), 32'h0);
    finish_cycle();
    check("no_stall_cnt", 32'(stall_cnt), 32'h0);

    // branch flush
    do_reset();
    step(0, 0, 0, BEQ);
    step(0, 0, 0, I1);
    apply(0, 0, 1, I2);
    check("beq_flush", 32'(flush), 32'h1);
    finish_cycle();
    check("beq_d_nop", instr_d, NOP);
    check("beq_x_nop", instr_x, NOP);
    check("beq_in_m", instr_m, BEQ);
    check("beq_flush_cnt", 32'(flush_cnt), 32'd1);

    // flush beats a simultaneous load-use hazard
    do_reset();
    step(0, 0, 0, LW5);
    step(0, 0, 0, ADD5);
    apply(0, 0, 1, FILL);
    check("fw_stall_low", 32'(stall), 32'h0);
    finish_cycle();
    check("fw_stall_cnt", 32'(stall_cnt), 32'h0);
    check("fw_flush_cnt", 32'(flush_cnt), 32'd1);
    check("fw_d_nop", instr_d, NOP);
    check("fw_lw_in_m", instr_m, LW5);

    // hold freezes a pending flush, which lands on the first free edge
    do_reset();
    step(0, 0, 0, BEQ);
    step(0, 0, 0, I1);
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 1, I2);
      check("hold_flush_low", 32'(flush), 32'h0);
      finish_cycle();
      check("hold_x_kept", instr_x, BEQ);
      check("hold_cnt_kept", 32'(flush_cnt), 32'h0);
    end
    step(0, 0, 1, I2);
    check("post_hold_x", instr_x, NOP);
    check("post_hold_m", instr_m, BEQ);
    check("post_hold_cnt", 32'(flush_cnt), 32'd1);

    // 2-bit counter saturates instead of wrapping
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 1, $urandom);
    check("sat_flush_3", 32'(s_flush_cnt), 32'd3);
    check("wide_flush_5", 32'(flush_cnt), 32'd5);

    // randomized traffic with a dense register pool to provoke hazards
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ins;
      logic [6:0]  ops [8];
      ops = '{7'b0000011, 7'b0110011, 7'b0100011, 7'b1100011,
              7'b0110111, 7'b0010111, 7'b1101111, 7'b0010011};
      ins        = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 7)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), ins);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_pipe_regs.md
Name: instr_pipe_regs

Overview:
- Owns the instruction and PC pipeline registers between fetch and writeback of the 5-stage RV32I core: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Produces instr_x, instr_m and instr_w for the control unit, and pc_d and pc_x for the datapath.
- Detects load-use hazards and inserts bubbles.
- Flushes wrong-path instructions when the execute-stage branch decision (pc_sel) is taken.
- Counts stall and flush events for debug.

Parameters:
- NOP, 32'h00000013, bubble encoding (addi x0,x0,0); harmless to control decode.
- RESET_PC, 32'h00000000, reset value of pc_d and pc_x.
- CNT_W, 16, width of the saturating event counters.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  global freeze (e.g. memory not ready); no register updates while high.
- instr_f  in  32  instruction from instruction memory, fetch stage.
- pc_f  in  32  PC of instr_f.
- pc_sel  in  1  branch/jump taken, computed from instr_x this cycle.
- instr_d  out  32  decode-stage instruction.
- pc_d  out  32  decode-stage PC.
- instr_x  out  32  execute-stage instruction.
- pc_x  out  32  execute-stage PC.
- instr_m  out  32  memory-stage instruction.
- instr_w  out  32  writeback-stage instruction.
- stall  out  1  combinational; PC register must hold when high.
- flush  out  1  combinational; equals pc_sel & !hold.
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  flush events, saturating.

Behaviour:
- Reset (rst=1 at edge):
  - instr_d, instr_x, instr_m, instr_w = NOP.
  - pc_d, pc_x = RESET_PC.
  - Counters = 0.
  - With NOP in X, stall=0 and flush=0 after reset.
  - Reset has priority over hold, in-flight hazards and flush; mid-operation reset discards all state in one cycle.
- Field extraction:
  - opcode = [6:0], rd = [11:7], rs1 = [19:15], rs2 = [24:20].
- Load-use hazard: instr_x opcode = 0000011 and rd_x != 0, and either:
  - rs1_d == rd_x and instr_d uses rs1 (all opcodes except 0110111 LUI, 0010111 AUIPC, 1101111 JAL); or
  - rs2_d == rd_x and instr_d uses rs2 (opcodes 0110011, 0100011, 1100011).
- stall = hazard & !pc_sel & !hold. Flush overrides the stall because the stalled instruction is wrong-path.
- Per edge, when hold=0, in priority order:
  1. pc_sel=1 (flush):
     - instr_d <= NOP, instr_x <= NOP.
     - instr_m <= instr_x, instr_w <= instr_m.
     - pc_d, pc_x are don't-care; keep previous values.
     - The fetch stage redirects the PC the same cycle.
  2. stall=1:
     - instr_d and pc_d hold.
     - instr_x <= NOP, pc_x holds.
     - M and W advance normally.
     - Exactly one bubble per load-use pair: after the bubble, instr_x is NOP, so the hazard clears.
  3. Otherwise:
     - instr_d <= instr_f, pc_d <= pc_f.
     - instr_x <= instr_d, pc_x <= pc_d.
     - instr_m <= instr_x, instr_w <= instr_m.
- hold=1: all registers and counters keep their values; stall=0, flush=0. A pending pc_sel or hazard takes effect on the first edge after hold falls.
- Counters:
  - stall_cnt increments on each edge with stall=1.
  - flush_cnt increments on each edge with flush=1.
  - Both saturate at all-ones, never wrap.
- Latency: an instruction reaches W four edges after it is sampled on instr_f, absent stalls, flushes and hold.

Decomposition:
- Shared package/header (rv_defs):
  - Opcode constants OP_LOAD, OP_STORE, OP_BRANCH, OP_OP, OP_LUI, OP_AUIPC, OP_JAL.
  - NOP encoding.
  - Field-slice macros/functions for rd/rs1/rs2.
- One natural sub-module: hazard_detect, purely combinational (instr_d, instr_x → hazard). Also reusable by a future forwarding unit.
- Counters stay inline.

Test Plan:
- Reset: assert rst 2 cycles with random instr_f → all instr_* = 32'h00000013, pc_d = pc_x = 0, stall_cnt = flush_cnt = 0.
- Straight-line flow: feed 32'h00100093, 32'h00200113, 32'h00308193, 32'h00410213 on consecutive cycles → each appears on instr_w exactly 4 edges after sampling, in order; no stall or flush.
- Load-use: lw x5,0(x1) followed by add x6,x5,x2 →
  - stall=1 for exactly one cycle, instr_x = NOP for one cycle, add held in D;
  - add reaches X one cycle later; stall_cnt = 1.
- Load-use rejected:
  - lw x0,0(x1) then add x6,x0,x2 → no stall.
  - lw x5 then lui x5,1 → no stall.
- Branch flush: beq in X with pc_sel=1 → next edge instr_d = instr_x = NOP, beq in M; flush_cnt = 1. With a simultaneous load-use hazard in D/X, the flush wins and stall_cnt is unchanged.
- Hold and saturation:
  - hold=1 for 5 cycles with pc_sel=1 → no state change; flush applied on the first edge after hold drops.
  - With CNT_W=2, 5 flushes → flush_cnt = 3.
